// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone arbiter for the shared SDRAM bus.
// Round-robin grant of whole cyc transactions, per-access ack watchdog and saturating abort counter.
module wshb_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 16,
    parameter int TIMEOUT  = 1024,
    parameter int ERRCNT_W = 8
) (
    input  logic                  CLK,
    input  logic                  NRST,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_adr,
    input  logic [DATA_W/8-1:0]   m0_sel,
    input  logic [DATA_W-1:0]     m0_dat_w,
    output logic [DATA_W-1:0]     m0_dat_r,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_adr,
    input  logic [DATA_W/8-1:0]   m1_sel,
    input  logic [DATA_W-1:0]     m1_dat_w,
    output logic [DATA_W-1:0]     m1_dat_r,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [ADDR_W-1:0]     s_adr,
    output logic [DATA_W/8-1:0]   s_sel,
    output logic [DATA_W-1:0]     s_dat_w,
    input  logic [DATA_W-1:0]     s_dat_r,
    input  logic                  s_ack,
    input  logic                  s_err,
    output logic [1:0]            grant,
    output logic [ERRCNT_W-1:0]   abort_cnt
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, FLUSH} state_t;

    state_t                state_q, state_d;
    logic                  last_owner_q, last_owner_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [ERRCNT_W-1:0]   abort_cnt_q, abort_cnt_d;
    logic                  abort_err_q, abort_err_d;

    logic cur;
    logic owner_cyc;
    logic other_cyc;
    logic stall;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic state_t own_state(input logic m);
        return m ? OWN1 : OWN0;
    endfunction

    // In FLUSH the aborted master is remembered in last_owner_q.
    assign cur       = (state_q == FLUSH) ? last_owner_q : (state_q == OWN1);
    assign owner_cyc = cur ? m1_cyc : m0_cyc;
    assign other_cyc = cur ? m0_cyc : m1_cyc;
    assign stall     = s_stb & ~s_ack & ~s_err;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        wd_d         = '0;
        abort_cnt_d  = abort_cnt_q;
        abort_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_cyc && m1_cyc) state_d = own_state(~last_owner_q);
                else if (m0_cyc)      state_d = OWN0;
                else if (m1_cyc)      state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (!owner_cyc) begin
                    last_owner_d = cur;
                    state_d      = other_cyc ? own_state(~cur) : IDLE;
                end else if (stall) begin
                    if (wd_q == WD_LAST) begin
                        state_d      = FLUSH;
                        last_owner_d = cur;
                        abort_err_d  = 1'b1;
                        abort_cnt_d  = sat_inc(abort_cnt_q);
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (!owner_cyc) state_d = other_cyc ? own_state(~cur) : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            wd_q         <= '0;
            abort_cnt_q  <= '0;
            abort_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            wd_q         <= wd_d;
            abort_cnt_q  <= abort_cnt_d;
            abort_err_q  <= abort_err_d;
        end
    end

    // Bus mux driven purely from the registered owner; slave ack is dropped outside OWNx.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_sel    = '0;
        s_dat_w  = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_dat_r = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_dat_r = '0;
        grant    = 2'b00;
        case (state_q)
            OWN0: begin
                grant    = 2'b01;
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_sel    = m0_sel;
                s_dat_w  = m0_dat_w;
                m0_ack   = s_ack;
                m0_err   = s_err;
                m0_dat_r = s_dat_r;
            end
            OWN1: begin
                grant    = 2'b10;
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_sel    = m1_sel;
                s_dat_w  = m1_dat_w;
                m1_ack   = s_ack;
                m1_err   = s_err;
                m1_dat_r = s_dat_r;
            end
            FLUSH: begin
                m0_err = abort_err_q & ~last_owner_q;
                m1_err = abort_err_q &  last_owner_q;
            end
            default: ;
        endcase
    end

    assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: bursts, contention, watchdog aborts, counter saturation and async reset.
module tb_wshb_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 16;
    localparam int SEL_W    = DATA_W / 8;
    localparam int TIMEOUT  = 16;
    localparam int ERRCNT_W = 8;

    logic clk = 1'b0;
    logic nrst;
    logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [ADDR_W-1:0] m0_adr, m1_adr, s_adr;
    logic [SEL_W-1:0]  m0_sel, m1_sel, s_sel;
    logic [DATA_W-1:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
    logic m0_ack, m0_err, m1_ack, m1_err;
    logic s_cyc, s_stb, s_we, s_ack, s_err;
    logic [1:0] grant;
    logic [ERRCNT_W-1:0] abort_cnt;

    int checks = 0;
    int failures = 0;
    int n0, n1;

    wshb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .CLK(clk), .NRST(nrst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
        .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
        .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .grant(grant), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_w = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_w = '0;
        s_err = 0; s_ack = 1; s_dat_r = 16'h5A5A;
        nrst = 0;

        // reset state, with a live slave ack that must not leak through
        #12;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_s_cyc", 32'(s_cyc), 32'h0);
        check("rst_s_stb", 32'(s_stb), 32'h0);
        check("rst_m0_ack", 32'(m0_ack), 32'h0);
        check("rst_m1_ack", 32'(m1_ack), 32'h0);
        check("rst_m0_dat_r", 32'(m0_dat_r), 32'h0);
        check("rst_abort_cnt", 32'(abort_cnt), 32'h0);
        s_ack = 0; s_dat_r = '0;
        @(negedge clk); nrst = 1;
        tick();

        // single m0 read burst of 8 accesses, ack after 3 cycles each
        m0_cyc = 1; m0_sel = 2'b11;
        #1 check("t1_grant_pre", 32'(grant), 32'h0);
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_s_cyc", 32'(s_cyc), 32'h1);
        for (int i = 0; i < 8; i++) begin
            m0_stb = 1; m0_adr = 32'h100 + 32'(2 * i);
            repeat (3) tick();
            check("t1_s_stb", 32'(s_stb), 32'h1);
            check("t1_s_adr", s_adr, 32'h100 + 32'(2 * i));
            check("t1_m0_ack_wait", 32'(m0_ack), 32'h0);
            s_ack = 1; s_dat_r = 16'hA000 + 16'(i);
            #1;
            check("t1_m0_ack", 32'(m0_ack), 32'h1);
            check("t1_m0_dat_r", 32'(m0_dat_r), 32'hA000 + 32'(i));
            check("t1_m1_ack", 32'(m1_ack), 32'h0);
            check("t1_m1_err", 32'(m1_err), 32'h0);
            check("t1_m1_dat_r", 32'(m1_dat_r), 32'h0);
            tick();
            s_ack = 0; m0_stb = 0;
        end
        m0_cyc = 0;
        tick();
        check("t1_grant_rel", 32'(grant), 32'h0);
        check("t1_s_cyc_rel", 32'(s_cyc), 32'h0);

        // simultaneous request after reset: m0 first, then m1 with no idle cycle
        nrst = 0; #3; nrst = 1;
        m0_cyc = 1; m1_cyc = 1; m1_stb = 1; m1_we = 1;
        m1_adr = 32'hDEADBEE0; m1_sel = 2'b10; m1_dat_w = 16'h1234;
        tick();
        check("t2_grant_m0", 32'(grant), 32'h1);
        check("t2_s_we_m0", 32'(s_we), 32'h0);
        m0_stb = 1; s_ack = 1; s_dat_r = 16'h7777;
        #1;
        check("t2_m0_ack", 32'(m0_ack), 32'h1);
        check("t2_m1_ack_blk", 32'(m1_ack), 32'h0);
        tick();
        m0_stb = 0; m0_cyc = 0; s_ack = 0;
        #1 check("t2_grant_hold", 32'(grant), 32'h1);
        tick();
        check("t2_grant_m1", 32'(grant), 32'h2);
        check("t2_s_cyc", 32'(s_cyc), 32'h1);
        check("t2_s_stb", 32'(s_stb), 32'h1);
        check("t2_s_we", 32'(s_we), 32'h1);
        check("t2_s_adr", s_adr, 32'hDEADBEE0);
        check("t2_s_sel", 32'(s_sel), 32'h2);
        check("t2_s_dat_w", 32'(s_dat_w), 32'h1234);
        check("t2_m1_ack_wait", 32'(m1_ack), 32'h0);
        s_ack = 1;
        #1;
        check("t2_m1_ack", 32'(m1_ack), 32'h1);
        check("t2_m0_ack", 32'(m0_ack), 32'h0);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        tick();
        check("t2_grant_idle", 32'(grant), 32'h0);

        // alternating contention over 100 single-access transactions
        m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
        n0 = 0; n1 = 0;
        tick();
        for (int n = 0; n < 100; n++) begin
            check("t3_grant", 32'(grant), (n % 2 == 0) ? 32'h1 : 32'h2);
            if (grant == 2'b01) n0++;
            else if (grant == 2'b10) n1++;
            s_ack = 1;
            #1;
            check("t3_owner_ack", (n % 2 == 0) ? 32'(m0_ack) : 32'(m1_ack), 32'h1);
            check("t3_other_ack", (n % 2 == 0) ? 32'(m1_ack) : 32'(m0_ack), 32'h0);
            tick();
            s_ack = 0;
            if (n % 2 == 0) begin m0_cyc = 0; m0_stb = 0; end
            else begin m1_cyc = 0; m1_stb = 0; end
            tick();
            if (n % 2 == 0) begin m0_cyc = 1; m0_stb = 1; end
            else begin m1_cyc = 1; m1_stb = 1; end
        end
        check("t3_m0_count", 32'(n0), 32'd50);
        check("t3_m1_count", 32'(n1), 32'd50);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        check("t3_grant_idle", 32'(grant), 32'h0);

        // m1 never acked: err pulse 16 cycles after stb, FLUSH, then m0 served
        check("t4_abort_cnt0", 32'(abort_cnt), 32'h0);
        m1_cyc = 1;
        tick();
        m1_stb = 1;
        #1;
        check("t4_s_stb", 32'(s_stb), 32'h1);
        check("t4_m1_err_c0", 32'(m1_err), 32'h0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("t4_m1_err_early", 32'(m1_err), 32'h0);
        end
        tick();
        check("t4_m1_err", 32'(m1_err), 32'h1);
        check("t4_m0_err", 32'(m0_err), 32'h0);
        check("t4_grant_flush", 32'(grant), 32'h0);
        check("t4_s_cyc_flush", 32'(s_cyc), 32'h0);
        check("t4_abort_cnt1", 32'(abort_cnt), 32'h1);
        m0_cyc = 1;
        tick();
        check("t4_m1_err_once", 32'(m1_err), 32'h0);
        check("t4_s_cyc_hold", 32'(s_cyc), 32'h0);
        check("t4_grant_hold", 32'(grant), 32'h0);
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("t4_grant_m0", 32'(grant), 32'h1);
        m0_stb = 1; s_ack = 1; s_dat_r = 16'h4242;
        #1;
        check("t4_m0_ack", 32'(m0_ack), 32'h1);
        check("t4_m0_dat_r", 32'(m0_dat_r), 32'h4242);
        tick();
        s_ack = 0; m0_stb = 0; m0_cyc = 0;
        tick();
        check("t4_grant_idle", 32'(grant), 32'h0);

        // 299 more aborts with a late ack on each abort cycle; counter saturates
        for (int k = 2; k <= 300; k++) begin
            m1_cyc = 1; m1_stb = 1;
            tick();
            repeat (15) tick();
            tick();
            s_ack = 1; s_dat_r = 16'hBEEF;
            #1;
            check("t5_late_m1_ack", 32'(m1_ack), 32'h0);
            check("t5_late_m0_ack", 32'(m0_ack), 32'h0);
            check("t5_m1_dat_r", 32'(m1_dat_r), 32'h0);
            check("t5_m1_err", 32'(m1_err), 32'h1);
            check("t5_abort_cnt", 32'(abort_cnt), (k > 255) ? 32'd255 : 32'(k));
            s_ack = 0; m1_cyc = 0; m1_stb = 0;
            tick();
        end
        check("t5_abort_sat", 32'(abort_cnt), 32'd255);

        // async reset while m1 owns the bus mid-access
        m0_cyc = 1;
        tick();
        m0_cyc = 0;
        tick();
        m1_cyc = 1; m1_stb = 1;
        tick();
        tick();
        check("t6_grant_m1", 32'(grant), 32'h2);
        s_ack = 1; s_dat_r = 16'h9999;
        #2 nrst = 0;
        #1;
        check("t6_s_cyc", 32'(s_cyc), 32'h0);
        check("t6_s_stb", 32'(s_stb), 32'h0);
        check("t6_grant", 32'(grant), 32'h0);
        check("t6_m1_ack", 32'(m1_ack), 32'h0);
        check("t6_m1_dat_r", 32'(m1_dat_r), 32'h0);
        check("t6_abort_cnt", 32'(abort_cnt), 32'h0);
        s_ack = 0; m1_stb = 0; m0_cyc = 1;
        @(negedge clk); nrst = 1;
        tick();
        check("t6_tie_m0", 32'(grant), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
